// File: rtl/cache_ctrl_fsm.sv
// Command sequencer between the OBI register fields and the key/value store.
// Define CACHE_CTRL_TIMEOUT_EN to abort commands stuck in ISSUE/WAIT after TimeoutCycles.
module cache_ctrl_fsm #(
  parameter int unsigned KeyWidth  = 64,
  parameter int unsigned DataWidth = 64
`ifdef CACHE_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles = 256
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           op_i,
  input  logic [KeyWidth-1:0]  key_i,
  input  logic [DataWidth-1:0] dat_i,
  output logic [DataWidth-1:0] dat_o,
  output logic                 data_valid_o,
  output logic                 busy_o,
  output logic                 busy_valid_o,
  output logic                 hit_o,
  output logic                 hit_valid_o,
  output logic [2:0]           op_o,
  output logic                 op_valid_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [1:0]           mem_op_o,
  output logic [KeyWidth-1:0]  mem_key_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic                 mem_hit_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic [2:0] {OP_NOP = 3'd0, OP_GET = 3'd1, OP_PUT = 3'd2, OP_DEL = 3'd3} op_e;

  state_e               state_q;
  logic [2:0]           op_q;
  logic [KeyWidth-1:0]  key_q;
  logic [DataWidth-1:0] dat_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 hit_q;
  logic                 busy_q;
  logic                 busy_valid_q;
  logic                 hit_valid_q;
  logic                 op_valid_q;
  logic                 data_valid_q;
  logic                 req_q;
  logic                 timeout;

`ifdef CACHE_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      key_q        <= '0;
      dat_q        <= '0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      busy_q       <= 1'b0;
      busy_valid_q <= 1'b0;
      hit_valid_q  <= 1'b0;
      op_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
      req_q        <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      busy_valid_q <= 1'b0;
      hit_valid_q  <= 1'b0;
      op_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
      if (state_q == S_START) cnt_q <= '0;
      else if (state_q == S_ISSUE || state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
`endif
      // Strobes are set on the transition so they are live exactly during DONE/START.
      case (state_q)
        S_IDLE: begin
          if (op_i != OP_NOP) begin
            op_q  <= op_i;
            hit_q <= 1'b0;
            if (op_i[2]) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              busy_valid_q <= 1'b1;
              hit_valid_q  <= 1'b1;
              op_valid_q   <= 1'b1;
            end else begin
              key_q        <= key_i;
              dat_q        <= dat_i;
              state_q      <= S_START;
              busy_q       <= 1'b1;
              busy_valid_q <= 1'b1;
            end
          end
        end
        S_START: begin
          state_q <= S_ISSUE;
          req_q   <= 1'b1;
        end
        S_ISSUE: begin
          if (timeout) begin
            state_q      <= S_DONE;
            req_q        <= 1'b0;
            hit_q        <= 1'b0;
            busy_q       <= 1'b0;
            busy_valid_q <= 1'b1;
            hit_valid_q  <= 1'b1;
            op_valid_q   <= 1'b1;
          end else if (mem_gnt_i) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state_q      <= S_DONE;
            hit_q        <= mem_hit_i;
            rdata_q      <= mem_rdata_i;
            data_valid_q <= (op_q == OP_GET) && mem_hit_i;
            busy_q       <= 1'b0;
            busy_valid_q <= 1'b1;
            hit_valid_q  <= 1'b1;
            op_valid_q   <= 1'b1;
          end else if (timeout) begin
            state_q      <= S_DONE;
            hit_q        <= 1'b0;
            busy_q       <= 1'b0;
            busy_valid_q <= 1'b1;
            hit_valid_q  <= 1'b1;
            op_valid_q   <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dat_o        = rdata_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;
  assign busy_valid_o = busy_valid_q;
  assign hit_o        = hit_q;
  assign hit_valid_o  = hit_valid_q;
  assign op_o         = '0;
  assign op_valid_o   = op_valid_q;
  assign mem_req_o    = req_q;
  assign mem_op_o     = op_q[1:0];
  assign mem_key_o    = key_q;
  assign mem_wdata_o  = dat_q;

endmodule
